// File: rtl/vecmac_job_ctrl.sv
// Job sequencer for the INT8 vector-MAC path: issues one operand read per beat,
// realigns accumulator strobes to the read latency and returns the result on a valid/ready port.
module vecmac_job_ctrl #(
    parameter int LANES     = 4,
    parameter int MAX_ELEMS = 1000,
    parameter int ADDR_W    = 10,
    parameter int RD_LAT    = 2,
    parameter int W_ACC     = 28,
    parameter int TIMEOUT   = 64,
    localparam int LEN_W    = $clog2(MAX_ELEMS + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic [ADDR_W-1:0] i_cmd_base,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_acc_clr,
    output logic              o_acc_in_valid,
    output logic              o_acc_last,
    output logic [LANES-1:0]  o_lane_mask,
    input  logic              i_acc_result_valid,
    input  logic [W_ACC-1:0]  i_acc_result,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [W_ACC-1:0]  o_res_sum,
    output logic              o_res_err,
    output logic              o_busy
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_DRAIN    = 3'd2,
        S_WAIT_ACC = 3'd3,
        S_HOLD     = 3'd4
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_beats_left;
    logic [ADDR_W-1:0]  r_addr;
    logic [TO_W-1:0]    r_to_cnt;
    logic               r_cmd_ready;
    logic               r_busy;
    logic               r_acc_clr;
    logic               r_rd_en;
    logic               r_rd_last;
    logic [LANES-1:0]   r_rd_mask;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_res_valid;
    logic               r_res_err;
    logic [W_ACC-1:0]   r_res_sum;
    logic [RD_LAT-1:0]  r_pv;
    logic [RD_LAT-1:0]  r_pl;
    logic [LANES-1:0]   r_pm [RD_LAT];

    logic [LEN_W:0]     w_len_pad;
    logic [LEN_W-1:0]   w_beats;
    logic [LEN_W-1:0]   w_rem;
    logic [LANES-1:0]   w_last_mask;
    logic               w_pipe_pending;

    assign w_len_pad = {1'b0, i_cmd_len} + (LEN_W+1)'(LANES - 1);
    assign w_beats   = LEN_W'(w_len_pad / (LEN_W+1)'(LANES));
    assign w_rem     = r_len % LEN_W'(LANES);

    always_comb begin
        w_last_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            w_last_mask[i] = (w_rem == '0) || (LEN_W'(i) < w_rem);
        end
    end

    // The output stage is excluded: it empties on the same edge DRAIN hands over.
    always_comb begin
        w_pipe_pending = r_rd_en;
        for (int k = 0; k < RD_LAT - 1; k++) begin
            w_pipe_pending = w_pipe_pending | r_pv[k];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pv <= '0;
            r_pl <= '0;
            for (int k = 0; k < RD_LAT; k++) r_pm[k] <= '0;
        end else begin
            for (int k = RD_LAT - 1; k > 0; k--) begin
                r_pv[k] <= r_pv[k-1];
                r_pl[k] <= r_pl[k-1];
                r_pm[k] <= r_pm[k-1];
            end
            r_pv[0] <= r_rd_en;
            r_pl[0] <= r_rd_last;
            r_pm[0] <= r_rd_mask;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_beats_left <= '0;
            r_addr       <= '0;
            r_to_cnt     <= '0;
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_acc_clr    <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_last    <= 1'b0;
            r_rd_mask    <= '0;
            r_rd_addr    <= '0;
            r_res_valid  <= 1'b0;
            r_res_err    <= 1'b0;
            r_res_sum    <= '0;
        end else begin
            r_acc_clr <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_last <= 1'b0;
            r_rd_mask <= '0;
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_len       <= i_cmd_len;
                        r_addr      <= i_cmd_base;
                        if (i_cmd_len == '0 || i_cmd_len > LEN_W'(MAX_ELEMS)) begin
                            r_state     <= S_HOLD;
                            r_res_valid <= 1'b1;
                            r_res_err   <= 1'b1;
                            r_res_sum   <= '0;
                        end else begin
                            r_state      <= S_ISSUE;
                            r_acc_clr    <= 1'b1;
                            r_beats_left <= w_beats;
                        end
                    end
                end
                S_ISSUE: begin
                    r_rd_en      <= 1'b1;
                    r_rd_addr    <= r_addr;
                    r_addr       <= r_addr + 1'b1;
                    r_beats_left <= r_beats_left - 1'b1;
                    if (r_beats_left == LEN_W'(1)) begin
                        r_rd_last <= 1'b1;
                        r_rd_mask <= w_last_mask;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_rd_mask <= '1;
                    end
                end
                S_DRAIN: begin
                    if (!w_pipe_pending) begin
                        r_state  <= S_WAIT_ACC;
                        r_to_cnt <= TO_W'(TIMEOUT - 1);
                    end
                end
                S_WAIT_ACC: begin
                    if (i_acc_result_valid) begin
                        r_state     <= S_HOLD;
                        r_res_valid <= 1'b1;
                        r_res_err   <= 1'b0;
                        r_res_sum   <= i_acc_result;
                    end else if (r_to_cnt == '0) begin
                        r_state     <= S_HOLD;
                        r_res_valid <= 1'b1;
                        r_res_err   <= 1'b1;
                        r_res_sum   <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (i_res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                        r_res_err   <= 1'b0;
                        r_res_sum   <= '0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready    = r_cmd_ready;
    assign o_busy         = r_busy;
    assign o_acc_clr      = r_acc_clr;
    assign o_rd_en        = r_rd_en;
    assign o_rd_addr      = r_rd_addr;
    assign o_acc_in_valid = r_pv[RD_LAT-1];
    assign o_acc_last     = r_pl[RD_LAT-1];
    assign o_lane_mask    = r_pm[RD_LAT-1];
    assign o_res_valid    = r_res_valid;
    assign o_res_err      = r_res_err;
    assign o_res_sum      = r_res_sum;

endmodule

// File: tb/tb_vecmac_job_ctrl.sv
// Scoreboard bench for vecmac_job_ctrl: stimulus pushes expected reads, beats and results;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_vecmac_job_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [9:0]  i_cmd_len = '0;
    logic [9:0]  i_cmd_base = '0;
    logic        o_rd_en;
    logic [9:0]  o_rd_addr;
    logic        o_acc_clr;
    logic        o_acc_in_valid;
    logic        o_acc_last;
    logic [3:0]  o_lane_mask;
    logic        i_acc_result_valid = 1'b0;
    logic [27:0] i_acc_result = '0;
    logic        o_res_valid;
    logic        i_res_ready = 1'b0;
    logic [27:0] o_res_sum;
    logic        o_res_err;
    logic        o_busy;

    vecmac_job_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_len(i_cmd_len), .i_cmd_base(i_cmd_base),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
        .o_acc_clr(o_acc_clr), .o_acc_in_valid(o_acc_in_valid),
        .o_acc_last(o_acc_last), .o_lane_mask(o_lane_mask),
        .i_acc_result_valid(i_acc_result_valid), .i_acc_result(i_acc_result),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_sum(o_res_sum), .o_res_err(o_res_err), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad = 0;
    int n_last = 0;
    int n_clr = 0;
    int exp_clr = 0;
    int last_acc_cyc = 0;
    int prev_rd_cyc = 0;

    int          exp_rd_q[$];   // addr | first_beat<<16
    int          rd_t_q[$];
    logic [4:0]  exp_acc_q[$];  // {last, mask}
    logic [28:0] exp_res_q[$];  // {err, sum}

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(string nm);
        total++;
        bad++;
        $display("FAIL %s: got no event want event (cycle %0d)", nm, cyc);
    endfunction

    always @(negedge clk) begin
        int e, t;
        logic [4:0] ea;
        logic [28:0] er;
        if (!rst) begin
            if (o_rd_en) begin
                if (exp_rd_q.size() == 0) fail_now("rd_unexpected_none");
                else begin
                    e = exp_rd_q.pop_front();
                    chk("rd_addr", int'(o_rd_addr), e & 16'hFFFF);
                    if (((e >> 16) & 1) == 0) chk("rd_contiguous", cyc - prev_rd_cyc, 1);
                    prev_rd_cyc = cyc;
                    rd_t_q.push_back(cyc);
                end
            end
            if (o_acc_in_valid) begin
                if (exp_acc_q.size() == 0 || rd_t_q.size() == 0) fail_now("acc_unexpected_none");
                else begin
                    ea = exp_acc_q.pop_front();
                    t  = rd_t_q.pop_front();
                    chk("acc_last_mask", int'({o_acc_last, o_lane_mask}), int'(ea));
                    chk("acc_latency", cyc - t, 2);
                    if (o_acc_last) begin
                        n_last++;
                        last_acc_cyc = cyc;
                    end
                end
            end else begin
                chk("acc_idle_zero", int'({o_acc_last, o_lane_mask}), 0);
            end
            if (o_acc_clr) n_clr++;
            if (o_res_valid && i_res_ready) begin
                if (exp_res_q.size() == 0) fail_now("res_unexpected_none");
                else begin
                    er = exp_res_q.pop_front();
                    chk("res_err", int'(o_res_err), int'(er[28]));
                    chk("res_sum", int'(o_res_sum), int'(er[27:0]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // dly: accumulator answers dly cycles after the last acc beat (0 = never answers)
    task automatic run_job(input int len, input int base, input int res, input int dly,
                           input int rdy_dly, input bit poke);
        int nb, rem, n0, k;
        bit is_err;
        logic [3:0] m;
        logic [28:0] er;
        is_err = (len == 0 || len > 1000);
        k = 0;
        while (!o_cmd_ready && k < 500) begin tick(); k++; end
        if (!o_cmd_ready) begin fail_now("cmd_ready_wait"); return; end
        if (is_err) er = {1'b1, 28'd0};
        else begin
            nb  = (len + 3) / 4;
            rem = len % 4;
            for (int i = 0; i < nb; i++) begin
                exp_rd_q.push_back(((base + i) % 1024) | ((i == 0) ? (1 << 16) : 0));
                m = (i == nb - 1 && rem != 0) ? 4'((1 << rem) - 1) : 4'hF;
                exp_acc_q.push_back({(i == nb - 1), m});
            end
            er = (dly == 0) ? {1'b1, 28'd0} : {1'b0, 28'(res)};
            exp_clr++;
        end
        exp_res_q.push_back(er);
        n0 = n_last;
        i_cmd_len   = 10'(len);
        i_cmd_base  = 10'(base);
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        chk("cmd_ready_low", int'(o_cmd_ready), 0);
        chk("busy_high", int'(o_busy), 1);
        if (is_err) begin
            chk("err_no_clr", int'(o_acc_clr), 0);
            chk("err_no_rd", int'(o_rd_en), 0);
            chk("err_res_valid", int'(o_res_valid), 1);
        end else begin
            chk("clr_pulse", int'(o_acc_clr), 1);
            chk("rd_after_clr", int'(o_rd_en), 0);
            tick();
            chk("clr_one_cycle", int'(o_acc_clr), 0);
            chk("rd_first", int'(o_rd_en), 1);
            k = 0;
            while (n_last == n0 && k < 2000) begin tick(); k++; end
            if (n_last == n0) begin fail_now("last_beat_wait"); return; end
            if (dly != 0) begin
                repeat (dly - 1) tick();
                i_acc_result_valid = 1'b1;
                i_acc_result = 28'(res);
                tick();
                i_acc_result_valid = 1'b0;
            end
        end
        k = 0;
        while (!o_res_valid && k < 200) begin tick(); k++; end
        if (!o_res_valid) begin fail_now("res_valid_wait"); return; end
        if (!is_err) begin
            // result visible the cycle after the accumulator strobe; timeout after 64 idle WAIT_ACC cycles
            chk((dly == 0) ? "timeout_cycles" : "res_latency", cyc - last_acc_cyc,
                (dly == 0) ? 65 : dly + 1);
        end
        for (int j = 0; j < rdy_dly; j++) begin
            chk("hold_valid", int'(o_res_valid), 1);
            chk("hold_sum", int'(o_res_sum), int'(er[27:0]));
            chk("hold_err", int'(o_res_err), int'(er[28]));
            chk("hold_cmd_ready", int'(o_cmd_ready), 0);
            if (poke) begin
                i_cmd_len   = 10'd4;
                i_cmd_base  = 10'h55;
                i_cmd_valid = 1'b1;
            end
            tick();
        end
        i_cmd_valid = 1'b0;
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
        chk("idle_cmd_ready", int'(o_cmd_ready), 1);
        chk("idle_res_valid", int'(o_res_valid), 0);
        chk("idle_busy", int'(o_busy), 0);
    endtask

    task automatic reset_mid_issue();
        int k;
        exp_clr++;
        i_cmd_len = 10'd16; i_cmd_base = 10'h40; i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        exp_rd_q.push_back(32'h40 | (1 << 16));
        k = 0;
        while (!(o_rd_en && o_rd_addr == 10'h41) && k < 20) begin
            if (o_rd_en) exp_rd_q.push_back(32'h41);
            tick();
            k++;
        end
        if (!(o_rd_en && o_rd_addr == 10'h41)) begin fail_now("mid_rst_beat1"); return; end
        rst = 1'b1;
        #1;
        chk("rst_rd_en", int'(o_rd_en), 0);
        chk("rst_acc_valid", int'(o_acc_in_valid), 0);
        chk("rst_acc_clr", int'(o_acc_clr), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_cmd_ready", int'(o_cmd_ready), 1);
        exp_rd_q.delete(); rd_t_q.delete(); exp_acc_q.delete(); exp_res_q.delete();
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int len, base, res, dly, rdy;
        tick(); tick();
        chk("reset_cmd_ready", int'(o_cmd_ready), 1);
        chk("reset_outputs", int'({o_rd_en, o_acc_clr, o_acc_in_valid, o_acc_last, o_lane_mask,
                                   o_res_valid, o_res_err, o_busy}), 0);
        chk("reset_sum", int'(o_res_sum), 0);
        rst = 1'b0;
        tick();

        run_job(8,    'h10,  'h1234,    5,  0, 1'b0);
        run_job(7,    'h20,  'h0777,    3,  1, 1'b0);
        run_job(1000, 'h3F0, 'h0FFFFFF, 10, 0, 1'b0);
        run_job(0,    'h00,  0,         0,  1, 1'b0);
        run_job(1001, 'h00,  0,         0,  0, 1'b0);
        run_job(5,    'h30,  'h0AAAA,   0,  0, 1'b0);
        run_job(6,    'h31,  'h0ABCDEF, 4,  5, 1'b1);
        run_job(1,    'h3FF, 'h0000001, 64, 0, 1'b0);
        reset_mid_issue();
        run_job(4,    'h100, 'h0CAFE01, 2,  0, 1'b0);

        for (int n = 0; n < 14; n++) begin
            case ($urandom_range(0, 5))
                0:       len = $urandom_range(1, 1000);
                1:       len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1001, 1023);
                default: len = $urandom_range(1, 40);
            endcase
            base = $urandom_range(0, 1023);
            res  = int'($urandom & 32'h0FFF_FFFF);
            dly  = $urandom_range(2, 60);
            rdy  = $urandom_range(0, 3);
            run_job(len, base, res, dly, rdy, 1'($urandom_range(0, 1)));
        end

        repeat (5) tick();
        chk("rd_q_left", exp_rd_q.size(), 0);
        chk("acc_q_left", exp_acc_q.size(), 0);
        chk("res_q_left", exp_res_q.size(), 0);
        chk("clr_count", n_clr, exp_clr);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog");
    end

endmodule
